// File: rtl/bp_common_pkg.sv
// Shared BlackParrot coherence-network types and width helpers, common to the
// response encoder and the receive-side decoders.
package bp_common_pkg;

  typedef enum logic [2:0] {
    e_lce_cce_sync_ack     = 3'b000,
    e_lce_cce_inv_ack      = 3'b001,
    e_lce_cce_coh_ack      = 3'b010,
    e_lce_cce_resp_wb      = 3'b011,
    e_lce_cce_resp_null_wb = 3'b100
  } bp_lce_cce_resp_type_e;

  localparam int unsigned lce_cce_resp_type_width_gp = 3;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // bp_lce_cce_resp_s is packed as {dst_id, src_id, msg_type, addr}.
  function automatic int unsigned lce_cce_resp_width(input int unsigned num_cce,
                                                     input int unsigned num_lce,
                                                     input int unsigned paddr_width);
    return safe_clog2(num_cce) + safe_clog2(num_lce) + lce_cce_resp_type_width_gp + paddr_width;
  endfunction

  // Network packet is {payload, length, y_cord, x_cord}.
  function automatic int unsigned network_packet_width(input int unsigned x_width,
                                                       input int unsigned y_width,
                                                       input int unsigned len_width,
                                                       input int unsigned payload_width);
    return x_width + y_width + len_width + payload_width;
  endfunction

  function automatic int unsigned network_flit_width(input int unsigned packet_width,
                                                     input int unsigned max_num_flit);
    return (packet_width + max_num_flit - 1) / max_num_flit;
  endfunction

endpackage

// File: rtl/bp_me_network_flit_assembler.sv
// Flit counter plus packet buffer; reassembles a multi-flit network packet.
// The header flit sets the remaining-flit count; body flits fill the buffer in order.
module bp_me_network_flit_assembler
  import bp_common_pkg::*;
#(
  parameter int unsigned max_num_flit_p = 3,
  parameter int unsigned flit_width_p   = 12,
  parameter int unsigned len_width_p    = 2,
  parameter int unsigned len_offset_p   = 5
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   hdr_v_i,
  input  logic                                   body_v_i,
  input  logic [flit_width_p-1:0]                flit_i,
  output logic                                   last_o,
  output logic [max_num_flit_p*flit_width_p-1:0] packet_o
);

  localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_num_flit_p - 1);

  logic [len_width_p-1:0] hdr_len_raw, hdr_len;
  logic [len_width_p-1:0] counter_q, len_q, body_idx;
  logic [max_num_flit_p-1:0][flit_width_p-1:0] buf_q;

  assign hdr_len_raw = flit_i[len_offset_p +: len_width_p];
  // Oversized length fields are clamped so the buffer index never overruns.
  assign hdr_len     = (hdr_len_raw > max_len_lp) ? max_len_lp : hdr_len_raw;
  assign body_idx    = len_q - counter_q + len_width_p'(1);
  assign last_o      = hdr_v_i ? (hdr_len == '0) : (counter_q == len_width_p'(1));
  assign packet_o    = buf_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      counter_q <= '0;
      len_q     <= '0;
    end else if (hdr_v_i) begin
      counter_q <= hdr_len;
      len_q     <= hdr_len;
    end else if (body_v_i) begin
      counter_q <= counter_q - len_width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (hdr_v_i) begin
      buf_q[0] <= flit_i;
    end else if (body_v_i) begin
      buf_q[body_idx] <= flit_i;
    end
  end

endmodule

// File: rtl/bp_me_network_resp_rx.sv
// LCE->CCE response network receiver: reassembles flits and presents the decoded
// response. Optional destination filtering under BP_ME_RESP_RX_DST_CHECK_EN.
module bp_me_network_resp_rx
  import bp_common_pkg::*;
#(
  // Defaults are placeholders; integrators always override them.
  parameter int unsigned num_lce_p      = 2,
  parameter int unsigned num_cce_p      = 2,
  parameter int unsigned paddr_width_p  = 22,
  parameter int unsigned max_num_flit_p = 3,
  parameter int unsigned x_cord_width_p = 3,
  parameter int unsigned y_cord_width_p = 2,
  parameter int unsigned my_x_cord_p    = 0,
  localparam int unsigned len_width_lp    = safe_clog2(max_num_flit_p),
  localparam int unsigned resp_width_lp   = lce_cce_resp_width(num_cce_p, num_lce_p,
                                                               paddr_width_p),
  localparam int unsigned packet_width_lp = network_packet_width(x_cord_width_p, y_cord_width_p,
                                                                 len_width_lp, resp_width_lp),
  localparam int unsigned flit_width_lp   = network_flit_width(packet_width_lp, max_num_flit_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     link_v_i,
  input  logic [flit_width_lp-1:0] link_data_i,
  output logic                     link_ready_o,
  output logic [resp_width_lp-1:0] resp_o,
  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic                     drop_o
);

  localparam int unsigned hdr_width_lp = x_cord_width_p + y_cord_width_p + len_width_lp;

  typedef enum logic [1:0] {StIdle, StRecv, StOut} state_e;

  state_e state_q, state_d;
  logic   xfer, hdr_v, body_v, asm_last, done;
  logic   hdr_mismatch, bad_q, pkt_bad, drop_set;
  logic [max_num_flit_p*flit_width_lp-1:0] packet;

  always_comb begin
    assert (flit_width_lp >= hdr_width_lp)
      else $error("bp_me_network_resp_rx: header does not fit in flit 0");
  end

  assign link_ready_o = ~reset_i & (state_q != StOut);
  assign xfer         = link_v_i & link_ready_o;
  assign hdr_v        = xfer & (state_q == StIdle);
  assign body_v       = xfer & (state_q == StRecv);
  assign done         = (hdr_v | body_v) & asm_last;
  assign pkt_bad      = hdr_v ? hdr_mismatch : bad_q;
  assign resp_v_o     = (state_q == StOut);
  assign resp_o       = packet[hdr_width_lp +: resp_width_lp];

  bp_me_network_flit_assembler #(
    .max_num_flit_p(max_num_flit_p),
    .flit_width_p  (flit_width_lp),
    .len_width_p   (len_width_lp),
    .len_offset_p  (x_cord_width_p + y_cord_width_p)
  ) u_assembler (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .hdr_v_i (hdr_v),
    .body_v_i(body_v),
    .flit_i  (link_data_i),
    .last_o  (asm_last),
    .packet_o(packet)
  );

  always_comb begin
    state_d  = state_q;
    drop_set = 1'b0;
    unique case (state_q)
      StIdle, StRecv: begin
        if (hdr_v) state_d = StRecv;
        if (done) begin
          state_d  = pkt_bad ? StIdle : StOut;
          drop_set = pkt_bad;
        end
      end
      StOut: if (resp_yumi_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

`ifdef BP_ME_RESP_RX_DST_CHECK_EN
  logic drop_q;

  assign hdr_mismatch = link_data_i[x_cord_width_p-1:0] != x_cord_width_p'(my_x_cord_p);
  assign drop_o       = drop_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bad_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_set;
      if (hdr_v) bad_q <= hdr_mismatch;
    end
  end
`else
  logic unused_cfg;

  assign hdr_mismatch = 1'b0;
  assign bad_q        = 1'b0;
  assign drop_o       = 1'b0;
  assign unused_cfg   = ^{drop_set, x_cord_width_p'(my_x_cord_p)};
`endif

  // Header fields and pad bits of the buffer are not part of the response.
  logic unused_packet;
  assign unused_packet = ^packet;

endmodule

// File: tb/tb_bp_me_network_resp_rx.sv
// Self-checking bench for bp_me_network_resp_rx with 3-flit packets; expects
// dropping only when BP_ME_RESP_RX_DST_CHECK_EN is defined.
module tb_bp_me_network_resp_rx;

  localparam int XW = 3, YW = 2, LW = 2, RW = 27, FW = 12, NF = 3;
  localparam logic [XW-1:0] MY_X = 3'd2;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          link_v_i = 1'b0;
  logic [FW-1:0] link_data_i = '0;
  logic          resp_yumi_i = 1'b0;
  logic          link_ready_o, resp_v_o, drop_o;
  logic [RW-1:0] resp_o;

  int total = 0;
  int bad   = 0;

  bp_me_network_resp_rx #(
    .num_lce_p     (2),
    .num_cce_p     (2),
    .paddr_width_p (22),
    .max_num_flit_p(NF),
    .x_cord_width_p(XW),
    .y_cord_width_p(YW),
    .my_x_cord_p   (2)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .link_v_i    (link_v_i),
    .link_data_i (link_data_i),
    .link_ready_o(link_ready_o),
    .resp_o      (resp_o),
    .resp_v_o    (resp_v_o),
    .resp_yumi_i (resp_yumi_i),
    .drop_o      (drop_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference packet: {payload, length, y, x}, cut into 12-bit flits from the LSB.
  function automatic logic [FW-1:0] make_flit(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                               input logic [LW-1:0] len,
                                               input logic [RW-1:0] pl, input int k);
    logic [NF*FW-1:0] p;
    p = {2'b00, pl, len, y, x};
    return p[k*FW +: FW];
  endfunction

  task automatic send(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [LW-1:0] len,
                      input logic [RW-1:0] pl, input int gap, input bit noise);
    int n;
    n = (len > 2) ? NF : int'(len) + 1;
    for (int k = 0; k < n; k++) begin
      if (k == 1) begin
        for (int g = 0; g < gap; g++) begin
          link_v_i = 1'b0;
          step();
          chk("gap_ready", link_ready_o, 1);
          chk("gap_resp_v", resp_v_o, 0);
        end
      end
      link_v_i    = 1'b1;
      link_data_i = make_flit(x, y, len, pl, k);
      resp_yumi_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("flit_ready", link_ready_o, 1);
      if (k > 0) chk("early_resp_v", resp_v_o, 0);
      step();
    end
    link_v_i    = 1'b0;
    resp_yumi_i = 1'b0;
  endtask

  task automatic expect_deliver(input logic [RW-1:0] pl, input int wait_cycles);
    chk("deliver_resp_v", resp_v_o, 1);
    chk("deliver_drop", drop_o, 0);
    for (int w = 0; w < wait_cycles; w++) begin
      chk("hold_ready", link_ready_o, 0);
      chk("hold_resp", resp_o, pl);
      step();
    end
    chk("deliver_resp", resp_o, pl);
    chk("deliver_not_ready", link_ready_o, 0);
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;
    chk("after_yumi_resp_v", resp_v_o, 0);
    chk("after_yumi_ready", link_ready_o, 1);
  endtask

  task automatic expect_mismatch(input logic [RW-1:0] pl);
`ifdef BP_ME_RESP_RX_DST_CHECK_EN
    chk("drop_pulse", drop_o, 1);
    chk("drop_resp_v", resp_v_o, 0);
    chk("drop_ready", link_ready_o, 1);
    step();
    chk("drop_end", drop_o, 0);
    chk("drop_resp_v2", resp_v_o, 0);
`else
    expect_deliver(pl, 0);
`endif
  endtask

  logic [RW-1:0] pa, pb;
  logic [XW-1:0] rx;
  logic [LW-1:0] rl;
  int            rgap;

  initial begin
    #1;
    chk("reset_ready", link_ready_o, 0);
    chk("reset_resp_v", resp_v_o, 0);
    chk("reset_drop", drop_o, 0);
    step();
    step();
    reset_i = 1'b0;
    #1;
    chk("idle_ready", link_ready_o, 1);

    // Back-to-back 3-flit packet.
    pa = RW'($urandom);
    send(MY_X, 2'd1, 2'd2, pa, 0, 0);
    expect_deliver(pa, 0);

    // Same packet with two idle cycles after the header.
    send(MY_X, 2'd1, 2'd2, pa, 2, 0);
    expect_deliver(pa, 0);

    // Consumer stalls 5 cycles while the next header is offered.
    pa = RW'($urandom);
    pb = RW'($urandom);
    send(MY_X, 2'd3, 2'd2, pa, 0, 0);
    link_v_i    = 1'b1;
    link_data_i = make_flit(MY_X, 2'd0, 2'd2, pb, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", link_ready_o, 0);
      chk("stall_resp_v", resp_v_o, 1);
      chk("stall_resp", resp_o, pa);
      step();
    end
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;
    send(MY_X, 2'd0, 2'd2, pb, 0, 0);
    expect_deliver(pb, 0);

    // Reset after the header of a packet; only the following packet is delivered.
    pa = RW'($urandom);
    pb = RW'($urandom);
    link_v_i    = 1'b1;
    link_data_i = make_flit(MY_X, 2'd2, 2'd2, pa, 0);
    step();
    link_v_i = 1'b0;
    reset_i  = 1'b1;
    #1;
    chk("midreset_ready", link_ready_o, 0);
    chk("midreset_resp_v", resp_v_o, 0);
    chk("midreset_drop", drop_o, 0);
    step();
    step();
    reset_i = 1'b0;
    step();
    chk("postreset_resp_v", resp_v_o, 0);
    send(MY_X, 2'd1, 2'd2, pb, 0, 0);
    expect_deliver(pb, 0);

    // Length field 3 exceeds max-1 and is clamped to a 3-flit packet.
    pa = RW'($urandom);
    send(MY_X, 2'd1, 2'd3, pa, 1, 0);
    expect_deliver(pa, 0);

    // Destination x_cord 4 against node x_cord 2.
    pa = RW'($urandom);
    send(3'd4, 2'd1, 2'd2, pa, 0, 0);
    expect_mismatch(pa);

    // Randomized packets with idle gaps, stray yumi and consumer delay.
    for (int t = 0; t < 12; t++) begin
      pa   = RW'($urandom);
      rx   = ($urandom_range(0, 1) == 1) ? MY_X : XW'($urandom);
      rl   = 2'($urandom_range(2, 3));
      rgap = $urandom_range(0, 3);
      send(rx, 2'($urandom), rl, pa, rgap, 1);
      if (rx != MY_X) expect_mismatch(pa);
      else            expect_deliver(pa, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
